// File: rtl/local_reg_bank.sv
// local_reg_bank
//   Register-file responder on the 0x90xx local read/write bus. It decodes an
//   8-bit address qualified by single-cycle Read/Write strobes. It holds the
//   control and scratch registers and issues one-cycle command strobes. It
//   also counts input events and accesses to undefined addresses.
//
//   Optional feature macro: LREG_TIMESTAMP_EN
//     Adds a free-running 32-bit timestamp at address 0x08. The timestamp can
//     be loaded by a write to that address. Without the macro, 0x08 is an
//     undefined address.
//
// Ports
//   Cclk      in   1   clock, rising edge
//   Reset_n   in   1   synchronous reset, active low
//   Address   in   8   local register address
//   DataOut   in   32  bus write data
//   DataIn    out  32  bus read data, registered, held until the next read
//   Read      in   1   read strobe
//   Write     in   1   write strobe
//   Ctrl0     out  32  CTRL0 register
//   Ctrl1     out  32  CTRL1 register
//   CmdPulse  out  8   one-cycle command strobes
//   Status    in   32  status word (Cclk domain)
//   EventIn   in   1   event level (Cclk domain); rising edges are counted
module local_reg_bank #(
    parameter logic [31:0] CTRL1_RST = 32'h0000_0000,
    parameter logic [31:0] BLOCK_ID  = 32'h9000_0001,
    parameter logic [31:0] UNDEF_VAL = 32'hDEAD_BEEF,
    parameter int          EVCNT_W   = 32
) (
    input  logic        Cclk,
    input  logic        Reset_n,
    input  logic [7:0]  Address,
    input  logic [31:0] DataOut,
    output logic [31:0] DataIn,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] Ctrl0,
    output logic [31:0] Ctrl1,
    output logic [7:0]  CmdPulse,
    input  logic [31:0] Status,
    input  logic        EventIn
);

    logic [31:0]        ctrl0;
    logic [31:0]        ctrl1;
    logic [31:0]        scratch;
    logic [7:0]         cmd_pulse;
    logic [31:0]        rd_data;
    logic [EVCNT_W-1:0] evcnt;
    logic [15:0]        errcnt;
    logic [31:0]        status_p1;
    logic               event_p1;
    logic [31:0]        tstamp;

    logic [31:0]        rdata;
    logic [31:0]        evcnt_ext;
    logic               addr_def;
    logic               ev_rise;

    function automatic logic [EVCNT_W-1:0] ev_sat_inc(input logic [EVCNT_W-1:0] v);
        return (&v) ? v : v + EVCNT_W'(1);
    endfunction

    function automatic logic [15:0] err_sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    assign ev_rise = EventIn & ~event_p1;

    // Read mux over the current (pre-write) register values. It also flags
    // whether the address is defined.
    always_comb begin
        evcnt_ext              = '0;
        evcnt_ext[EVCNT_W-1:0] = evcnt;
        addr_def               = 1'b1;
        rdata                  = UNDEF_VAL;
        case (Address)
            8'h00: rdata = ctrl0;
            8'h01: rdata = ctrl1;
            8'h02: rdata = 32'h0;
            8'h03: rdata = status_p1;
            8'h04: rdata = evcnt_ext;
            8'h05: rdata = scratch;
            8'h06: rdata = {16'h0, errcnt};
            8'h07: rdata = BLOCK_ID;
`ifdef LREG_TIMESTAMP_EN
            8'h08: rdata = tstamp;
`endif
            default: begin
                rdata    = UNDEF_VAL;
                addr_def = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Cclk) begin
        if (!Reset_n) begin
            ctrl0     <= 32'h0;
            ctrl1     <= CTRL1_RST;
            scratch   <= 32'h0;
            cmd_pulse <= 8'h0;
            rd_data   <= 32'h0;
            evcnt     <= '0;
            errcnt    <= 16'h0;
            status_p1 <= 32'h0;
            event_p1  <= 1'b0;
        end else begin
            status_p1 <= Status;
            event_p1  <= EventIn;

            // The strobe is rebuilt every cycle, so back-to-back CMD writes
            // give back-to-back pulses and never accumulate bits.
            cmd_pulse <= (Write && Address == 8'h02) ? DataOut[7:0] : 8'h0;

            if (Write) begin
                case (Address)
                    8'h00:   ctrl0   <= DataOut;
                    8'h01:   ctrl1   <= DataOut;
                    8'h05:   scratch <= DataOut;
                    default: ;
                endcase
            end

            // The read captures pre-write values, so a simultaneous
            // read/write returns the old contents.
            if (Read)
                rd_data <= rdata;

            // A clear wins over a coincident increment.
            if (Write && Address == 8'h04)
                evcnt <= '0;
            else if (ev_rise)
                evcnt <= ev_sat_inc(evcnt);

            // Read and Write on the same edge count as a single access.
            if (Write && Address == 8'h06)
                errcnt <= 16'h0;
            else if ((Read || Write) && !addr_def)
                errcnt <= err_sat_inc(errcnt);
        end
    end

`ifdef LREG_TIMESTAMP_EN
    always_ff @(posedge Cclk) begin
        if (!Reset_n)
            tstamp <= 32'h0;
        else if (Write && Address == 8'h08)
            tstamp <= DataOut;
        else
            tstamp <= tstamp + 32'd1;
    end
`else
    assign tstamp = 32'h0;
`endif

    assign Ctrl0    = ctrl0;
    assign Ctrl1    = ctrl1;
    assign CmdPulse = cmd_pulse;
    assign DataIn   = rd_data;

endmodule

// File: tb/tb_local_reg_bank.sv
module tb_local_reg_bank;

    localparam logic [31:0] CTRL1_RST = 32'h0000_00C1;
    localparam logic [31:0] BLOCK_ID  = 32'h9000_0001;
    localparam logic [31:0] UNDEF_VAL = 32'hDEAD_BEEF;
    localparam int          EVCNT_W   = 3;

    logic        Cclk;
    logic        Reset_n;
    logic [7:0]  Address;
    logic [31:0] DataOut;
    logic [31:0] DataIn;
    logic        Read;
    logic        Write;
    logic [31:0] Ctrl0;
    logic [31:0] Ctrl1;
    logic [7:0]  CmdPulse;
    logic [31:0] Status;
    logic        EventIn;

    int n_tests = 0;
    int n_fail  = 0;

    local_reg_bank #(
        .CTRL1_RST (CTRL1_RST),
        .BLOCK_ID  (BLOCK_ID),
        .UNDEF_VAL (UNDEF_VAL),
        .EVCNT_W   (EVCNT_W)
    ) dut (
        .Cclk     (Cclk),
        .Reset_n  (Reset_n),
        .Address  (Address),
        .DataOut  (DataOut),
        .DataIn   (DataIn),
        .Read     (Read),
        .Write    (Write),
        .Ctrl0    (Ctrl0),
        .Ctrl1    (Ctrl1),
        .CmdPulse (CmdPulse),
        .Status   (Status),
        .EventIn  (EventIn)
    );

    initial Cclk = 1'b0;
    always #5 Cclk = ~Cclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns past it.
    task automatic tick();
        @(posedge Cclk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        Address = a; DataOut = d; Write = 1'b1;
        tick();
        Write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a);
        Address = a; Read = 1'b1;
        tick();
        Read = 1'b0;
    endtask

    task automatic ev_pulse();
        EventIn = 1'b1; tick();
        EventIn = 1'b0; tick();
    endtask

    initial begin
        Reset_n = 1'b0; Address = 8'h0; DataOut = 32'h0;
        Read = 1'b0; Write = 1'b0; Status = 32'h0; EventIn = 1'b0;

        // Reset
        tick(); tick();
        check("rst_ctrl0", Ctrl0, 32'h0);
        check("rst_ctrl1", Ctrl1, CTRL1_RST);
        check("rst_cmd", {24'h0, CmdPulse}, 32'h0);
        check("rst_datain", DataIn, 32'h0);
        Reset_n = 1'b1;
        tick();
        bus_read(8'h07);
        check("id", DataIn, 32'h9000_0001);

        // Scratch and CMD readback
        bus_write(8'h05, 32'h1234_5678);
        bus_read(8'h05);
        check("scratch", DataIn, 32'h1234_5678);
        bus_read(8'h02);
        check("cmd_rd0", DataIn, 32'h0);

        // CMD strobes
        bus_write(8'h02, 32'h0000_00A5);
        check("cmd_a5", {24'h0, CmdPulse}, 32'hA5);
        tick();
        check("cmd_a5_off", {24'h0, CmdPulse}, 32'h0);
        Address = 8'h02; DataOut = 32'h01; Write = 1'b1;
        tick();
        check("cmd_b2b_01", {24'h0, CmdPulse}, 32'h01);
        DataOut = 32'h80;
        tick();
        check("cmd_b2b_80", {24'h0, CmdPulse}, 32'h80);
        Write = 1'b0;
        tick();
        check("cmd_b2b_off", {24'h0, CmdPulse}, 32'h0);

        // Control registers
        bus_write(8'h00, 32'h0000_0011);
        check("ctrl0_wr", Ctrl0, 32'h11);
        bus_write(8'h01, 32'h0000_ABCD);
        check("ctrl1_wr", Ctrl1, 32'hABCD);

        // Read-only writes are ignored and are not errors
        bus_write(8'h07, 32'h0);
        bus_write(8'h03, 32'h0);
        bus_read(8'h07);
        check("id_ro", DataIn, 32'h9000_0001);
        bus_read(8'h06);
        check("err_ro_none", DataIn, 32'h0);

        // Status is one cycle old at the read edge
        Status = 32'h0000_CAFE;
        tick();
        Status = 32'h0000_BEEF;
        bus_read(8'h03);
        check("status_dly", DataIn, 32'h0000_CAFE);

        // Event counting: 3 pulses + a 10-cycle high level = 4 edges
        ev_pulse(); ev_pulse(); ev_pulse();
        EventIn = 1'b1;
        repeat (10) tick();
        EventIn = 1'b0;
        tick();
        bus_read(8'h04);
        check("evcnt4", DataIn, 32'd4);
        // Clear coincident with a rising edge: the clear wins
        EventIn = 1'b1; Address = 8'h04; Write = 1'b1;
        tick();
        Write = 1'b0;
        tick();
        EventIn = 1'b0;
        bus_read(8'h04);
        check("evcnt_clr", DataIn, 32'd0);
        // 3-bit counter saturates at 7
        repeat (9) ev_pulse();
        bus_read(8'h04);
        check("evcnt_sat", DataIn, 32'd7);

        // Undefined addresses
        bus_read(8'h3F);
        check("undef_3f", DataIn, UNDEF_VAL);
        bus_read(8'hFF);
        check("undef_ff", DataIn, UNDEF_VAL);
        bus_read(8'h06);
        check("errcnt2", DataIn, 32'd2);
        bus_write(8'h20, 32'h5);
        Address = 8'h40; Read = 1'b1; Write = 1'b1;
        tick();
        Read = 1'b0; Write = 1'b0;
        bus_read(8'h06);
        check("errcnt_rw_once", DataIn, 32'd4);
`ifndef LREG_TIMESTAMP_EN
        bus_read(8'h08);
        check("undef_08", DataIn, UNDEF_VAL);
        bus_read(8'h06);
        check("errcnt_08", DataIn, 32'd5);
`endif

        // ERRCNT saturation: clear, then 65534 undefined reads, then two more
        bus_write(8'h06, 32'h0);
        bus_read(8'h06);
        check("errcnt_clr", DataIn, 32'd0);
        Address = 8'hFF; Read = 1'b1;
        repeat (65534) @(posedge Cclk);
        #1;
        Read = 1'b0;
        bus_read(8'h06);
        check("errcnt_fffe", DataIn, 32'h0000_FFFE);
        bus_read(8'hFF);
        bus_read(8'hFF);
        bus_read(8'h06);
        check("errcnt_sat", DataIn, 32'h0000_FFFF);

        // Simultaneous read/write on CTRL0
        Address = 8'h00; DataOut = 32'h22; Read = 1'b1; Write = 1'b1;
        tick();
        Read = 1'b0; Write = 1'b0;
        check("rw_old", DataIn, 32'h11);
        check("rw_new", Ctrl0, 32'h22);

        // Reset in the middle of an access aborts it
        Address = 8'h05; DataOut = 32'h99; Write = 1'b1; Reset_n = 1'b0;
        tick();
        Write = 1'b0; Reset_n = 1'b1;
        check("rst_mid_ctrl1", Ctrl1, CTRL1_RST);
        Address = 8'h02; DataOut = 32'h3C; Write = 1'b1; Reset_n = 1'b0;
        tick();
        Write = 1'b0; Reset_n = 1'b1;
        check("rst_mid_cmd", {24'h0, CmdPulse}, 32'h0);
        bus_read(8'h05);
        check("rst_mid_scratch", DataIn, 32'h0);

`ifdef LREG_TIMESTAMP_EN
        // Timestamp load and wrap
        bus_write(8'h08, 32'hFFFF_FFFE);
        Address = 8'h08; Read = 1'b1;
        tick();
        check("ts_fffe", DataIn, 32'hFFFF_FFFE);
        tick();
        check("ts_ffff", DataIn, 32'hFFFF_FFFF);
        tick();
        check("ts_wrap", DataIn, 32'h0);
        Read = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
